// File: rtl/cache_pkg.sv
// Shared definitions for the write-back cache controller: FSM state encoding,
// default geometry and helpers that derive tag width and line count.
package cache_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_INDEX_W = 7;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        ARB_WAIT  = 3'd2,
        WRITEBACK = 3'd3,
        FILL      = 3'd4,
        RESPOND   = 3'd5
    } cache_wb_state_t;

    function automatic int tag_bits(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    function automatic int line_count(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: tag/data arrays (not reset) plus valid/dirty
// vectors (reset to 0).
// Ports: clk/rst_n; combinational read port (rd_idx -> tag/data/valid/dirty);
// write port (wr_en/idx/tag/data/dirty, sets valid); invalidate port
// (inv_en/idx/tag) that clears valid+dirty only when the stored tag matches.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_dirty,
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_idx,
    input  logic [TAG_W-1:0]   inv_tag
);
    localparam int LINES = line_count(INDEX_W);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic              inv_match;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];

    // Snoops carry a full address; only a live copy of that exact line is dropped.
    assign inv_match = valid[inv_idx] && (tag_mem[inv_idx] == inv_tag);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // The controller never invalidates the index it is writing in the same
    // cycle; write is ordered last so an install would win regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (inv_en && inv_match) begin
                valid[inv_idx] <= 1'b0;
                dirty[inv_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
                dirty[wr_idx] <= wr_dirty;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Per-core direct-mapped write-back / write-allocate cache controller.
// Ports: cpu_* single-outstanding request/response (cpu_gnt one-cycle pulse);
// arb_req/arb_gnt bus arbitration; mem_* memory transaction (mem_ready pulse);
// snoop_inv/snoop_addr remote invalidate; hit_cnt/miss_cnt saturating counters.
module cache_ctrl_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              cpu_gnt,
    output logic              arb_req,
    input  logic              arb_gnt,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = tag_bits(ADDR_W, INDEX_W);

    cache_wb_state_t state, nxt;

    logic              rw_q, hit_q;
    logic [ADDR_W-1:0] addr_q, pend_addr, inv_addr;
    logic [DATA_W-1:0] wdata_q, rdata_q, wr_data;
    logic              pend_v, inv_en, wr_en, wr_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_dirty, hit;

    wire [INDEX_W-1:0] idx_q = addr_q[INDEX_W-1:0];
    wire [TAG_W-1:0]   tag_q = addr_q[ADDR_W-1:INDEX_W];

    cache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (idx_q),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_tag  (tag_q),
        .wr_data (wr_data),
        .wr_dirty(wr_dirty),
        .inv_en  (inv_en),
        .inv_idx (inv_addr[INDEX_W-1:0]),
        .inv_tag (inv_addr[ADDR_W-1:INDEX_W])
    );

    // Read port stays on the in-flight index, so from ARB_WAIT onward it
    // presents the victim line until the new line is installed.
    assign hit = rd_valid && (rd_tag == tag_q);

    always_comb begin
        nxt      = state;
        wr_en    = 1'b0;
        wr_data  = wdata_q;
        wr_dirty = 1'b1;
        case (state)
            IDLE:     if (cpu_valid) nxt = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    nxt   = RESPOND;
                    wr_en = !rw_q;
                end else begin
                    nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (arb_gnt) begin
                    if (rd_valid && rd_dirty) nxt = WRITEBACK;
                    else if (rw_q)            nxt = FILL;
                    else begin
                        nxt   = RESPOND;
                        wr_en = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    if (rw_q) nxt = FILL;
                    else begin
                        nxt   = RESPOND;
                        wr_en = 1'b1;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    nxt      = RESPOND;
                    wr_en    = 1'b1;
                    wr_data  = mem_rdata;
                    wr_dirty = 1'b0;
                end
            end
            RESPOND:  nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Snoops to other lines apply at once via the dedicated invalidate port.
    // A snoop to the in-flight index is parked and replayed in IDLE, where a
    // fresh snoop in the same cycle supersedes it.
    always_comb begin
        inv_en   = 1'b0;
        inv_addr = snoop_addr;
        if (state == IDLE) begin
            if (snoop_inv) begin
                inv_en = 1'b1;
            end else if (pend_v) begin
                inv_en   = 1'b1;
                inv_addr = pend_addr;
            end
        end else if (snoop_inv && (snoop_addr[INDEX_W-1:0] != idx_q)) begin
            inv_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            rdata_q   <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && cpu_valid) begin
                rw_q    <= cpu_rw;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                hit_q   <= hit;
                rdata_q <= (hit && rw_q) ? rd_data : '0;
                if (hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                end
            end
            if (state == FILL && mem_ready) rdata_q <= mem_rdata;
            if (state == IDLE) begin
                pend_v <= 1'b0;
            end else if (snoop_inv && (snoop_addr[INDEX_W-1:0] == idx_q)) begin
                pend_v    <= 1'b1;
                pend_addr <= snoop_addr;
            end
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    assign arb_req   = (state == ARB_WAIT) || (state == WRITEBACK) || (state == FILL);
    assign mem_valid = (state == WRITEBACK) || (state == FILL);
    assign mem_rw    = (state == FILL);
    assign mem_addr  = (state == WRITEBACK) ? {rd_tag, idx_q} :
                       (state == FILL)      ? addr_q : '0;
    assign mem_wdata = (state == WRITEBACK) ? rd_data : '0;
    assign cpu_gnt   = (state == RESPOND);
    assign cpu_hit   = (state == RESPOND) && hit_q;
    assign cpu_rdata = (state == RESPOND) ? rdata_q : '0;

endmodule
